// File: rtl/video_layer_fetch_if.sv
// VRAM read port shared by the layer fetcher (master) and the VRAM arbiter (slave).
interface video_layer_fetch_if;
    logic [14:0] vram_addr;
    logic        vram_strobe;
    logic        vram_ack;
    logic [31:0] vram_data;

    modport master (output vram_addr, vram_strobe, input vram_ack, vram_data);
    modport slave  (input vram_addr, vram_strobe, output vram_ack, vram_data);
endinterface

// File: rtl/video_layer_fetch.sv
// Per-layer scanline prefetcher: VRAM words -> byte-wide double-banked line buffer.
// Optional build macro VIDEO_FETCH_LINE_DOUBLE_EN repeats each source line on two scanlines.
module video_layer_fetch #(
    parameter int LINE_PIXELS  = 640,
    parameter int ACTIVE_LINES = 480,
    parameter int STRIDE_WORDS = 160
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       next_frame_i,
    input  logic                       next_line_i,
    input  logic                       layer_enable_i,
    input  logic [14:0]                fb_base_i,
    video_layer_fetch_if.master        vram,
    output logic [10:0]                buff_addr_o,
    output logic [7:0]                 buff_data_o,
    output logic                       buff_we_o,
    output logic                       display_bank_o,
    output logic                       busy_o,
    output logic                       overrun_o
);
    localparam logic [7:0]  LAST_WORD  = 8'(LINE_PIXELS / 4 - 1);
    localparam logic [10:0] LINE_LIMIT = 11'(ACTIVE_LINES);
    localparam logic [14:0] STRIDE     = 15'(STRIDE_WORDS);

    typedef enum logic [1:0] {IDLE, REQ, UNPACK, DRAIN} state_t;

    state_t      state, state_nx;
    logic [14:0] line_addr, line_addr_new, req_addr, addr_step;
    logic [9:0]  line_cnt, line_cnt_inc;
    logic [7:0]  word_cnt;
    logic [1:0]  byte_sel;
    logic [31:0] data_p1;
    logic        wr_bank;
    logic        pend, pend_nx;
    logic        boundary, want_fetch, writing;
    logic        start, advance, take;

    function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] sel);
        case (sel)
            2'd0:    return word[7:0];
            2'd1:    return word[15:8];
            2'd2:    return word[23:16];
            default: return word[31:24];
        endcase
    endfunction

    assign boundary     = next_frame_i | next_line_i;
    assign line_cnt_inc = line_cnt + 10'd1;

`ifdef VIDEO_FETCH_LINE_DOUBLE_EN
    // Source address moves on only after the second scanline of each pair.
    assign addr_step = line_cnt[0] ? STRIDE : 15'd0;
`else
    assign addr_step = STRIDE;
`endif

    assign line_addr_new = next_frame_i ? fb_base_i :
                           next_line_i  ? line_addr + addr_step : line_addr;
    assign want_fetch    = layer_enable_i &
                           (next_frame_i | ({1'b0, line_cnt_inc} < LINE_LIMIT));

    // A boundary during unpack kills the write in the same cycle.
    assign writing        = (state == UNPACK) && !boundary;
    assign buff_we_o      = writing;
    assign buff_addr_o    = writing ? {wr_bank, word_cnt, byte_sel} : 11'd0;
    assign buff_data_o    = writing ? select_byte(data_p1, byte_sel) : 8'd0;
    assign vram.vram_addr   = req_addr;
    assign vram.vram_strobe = (state == REQ) || (state == DRAIN);
    assign busy_o           = (state != IDLE);

    always_comb begin
        state_nx = state;
        pend_nx  = pend;
        start    = 1'b0;
        advance  = 1'b0;
        take     = 1'b0;
        case (state)
            IDLE: begin
                if (boundary && want_fetch) begin
                    start    = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (boundary) begin
                    if (vram.vram_ack) begin
                        start    = want_fetch;
                        state_nx = want_fetch ? REQ : IDLE;
                    end else begin
                        pend_nx  = want_fetch;
                        state_nx = DRAIN;
                    end
                end else if (vram.vram_ack) begin
                    take     = 1'b1;
                    state_nx = UNPACK;
                end
            end
            UNPACK: begin
                if (boundary) begin
                    start    = want_fetch;
                    state_nx = want_fetch ? REQ : IDLE;
                end else if (byte_sel == 2'd3) begin
                    if (word_cnt == LAST_WORD || !layer_enable_i) begin
                        state_nx = IDLE;
                    end else begin
                        advance  = 1'b1;
                        state_nx = REQ;
                    end
                end
            end
            DRAIN: begin
                // The orphaned request must be acked before the new line is requested.
                if (boundary)
                    pend_nx = want_fetch;
                if (vram.vram_ack) begin
                    if (boundary ? want_fetch : pend) begin
                        start    = 1'b1;
                        state_nx = REQ;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            pend           <= 1'b0;
            line_addr      <= 15'd0;
            line_cnt       <= 10'd0;
            word_cnt       <= 8'd0;
            byte_sel       <= 2'd0;
            req_addr       <= 15'd0;
            wr_bank        <= 1'b1;
            display_bank_o <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            state     <= state_nx;
            pend      <= pend_nx;
            overrun_o <= boundary & busy_o;
            if (next_frame_i) begin
                line_addr <= fb_base_i;
                line_cnt  <= 10'd0;
            end else if (next_line_i) begin
                line_addr      <= line_addr_new;
                line_cnt       <= line_cnt_inc;
                display_bank_o <= wr_bank;
                wr_bank        <= ~wr_bank;
            end
            if (start) begin
                word_cnt <= 8'd0;
                req_addr <= line_addr_new;
            end else if (advance) begin
                word_cnt <= word_cnt + 8'd1;
                req_addr <= req_addr + 15'd1;
            end
            if (take)
                byte_sel <= 2'd0;
            else if (writing)
                byte_sel <= byte_sel + 2'd1;
        end
    end

    // Fetched word holds pure data; it is only consumed while unpacking.
    always_ff @(posedge clk_i) begin
        if (take)
            data_p1 <= vram.vram_data;
    end
endmodule

// File: tb/tb_video_layer_fetch.sv
// Scoreboard bench for video_layer_fetch: VRAM responder pushes expected line-buffer writes.
module tb_video_layer_fetch;
    localparam int STRIDE = 160;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        next_frame = 1'b0;
    logic        next_line = 1'b0;
    logic        layer_enable = 1'b0;
    logic [14:0] fb_base = 15'd0;
    logic [10:0] buff_addr;
    logic [7:0]  buff_data;
    logic        buff_we, display_bank, busy, overrun;

    video_layer_fetch_if vif();

    video_layer_fetch dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .next_frame_i   (next_frame),
        .next_line_i    (next_line),
        .layer_enable_i (layer_enable),
        .fb_base_i      (fb_base),
        .vram           (vif),
        .buff_addr_o    (buff_addr),
        .buff_data_o    (buff_data),
        .buff_we_o      (buff_we),
        .display_bank_o (display_bank),
        .busy_o         (busy),
        .overrun_o      (overrun)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    logic [18:0] sb[$];
    logic [18:0] mon_exp;
    logic [14:0] last_req;
    logic [14:0] exp_line_addr;
    logic [9:0]  exp_cnt;
    logic        exp_wr, exp_disp;

    // Every line-buffer write must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        if (rst_n && buff_we) begin
            wr_count++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL buff_write_unexpected: got addr=%h data=%h, required no write", buff_addr, buff_data);
            end else begin
                mon_exp = sb.pop_front();
                if ({buff_addr, buff_data} !== mon_exp) begin
                    errors++;
                    $display("FAIL buff_write: got addr=%h data=%h, required addr=%h data=%h",
                             buff_addr, buff_data, mon_exp[18:8], mon_exp[7:0]);
                end
            end
        end
    end

    task automatic pulse_frame(input logic [14:0] base);
        @(negedge clk);
        fb_base = base;
        next_frame = 1'b1;
        @(negedge clk);
        next_frame = 1'b0;
        exp_line_addr = base;
        exp_cnt = 10'd0;
    endtask

    task automatic pulse_both(input logic [14:0] base);
        @(negedge clk);
        fb_base = base;
        next_frame = 1'b1;
        next_line = 1'b1;
        @(negedge clk);
        next_frame = 1'b0;
        next_line = 1'b0;
        exp_line_addr = base;
        exp_cnt = 10'd0;
    endtask

    task automatic pulse_line();
        @(negedge clk);
        next_line = 1'b1;
        @(negedge clk);
        next_line = 1'b0;
`ifdef VIDEO_FETCH_LINE_DOUBLE_EN
        if (exp_cnt[0]) exp_line_addr = exp_line_addr + 15'(STRIDE);
`else
        exp_line_addr = exp_line_addr + 15'(STRIDE);
`endif
        exp_cnt  = exp_cnt + 10'd1;
        exp_disp = exp_wr;
        exp_wr   = ~exp_wr;
    endtask

    task automatic wait_strobe(input string name);
        int t = 0;
        while (vif.vram_strobe !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (vif.vram_strobe !== 1'b1) begin
            errors++;
            $display("FAIL %s_strobe_timeout: got strobe=%b, required 1", name, vif.vram_strobe);
        end
    endtask

    task automatic serve_word(input logic [14:0] a, input logic [31:0] d, input bit push,
                              input bit bank, input int word);
        int t = 0;
        @(negedge clk);
        while (vif.vram_strobe !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (vif.vram_strobe !== 1'b1) begin
            errors++;
            $display("FAIL vram_req_timeout word %0d: got strobe=%b, required 1", word, vif.vram_strobe);
        end else begin
            checks++;
            if (vif.vram_addr !== a) begin
                errors++;
                $display("FAIL vram_addr word %0d: got %h, required %h", word, vif.vram_addr, a);
            end
            last_req = vif.vram_addr;
            if (push)
                for (int b = 0; b < 4; b++)
                    sb.push_back({bank, 10'(word * 4 + b), d[8*b +: 8]});
            vif.vram_ack  = 1'b1;
            vif.vram_data = d;
            @(negedge clk);
            vif.vram_ack  = 1'b0;
        end
    endtask

    task automatic serve_line(input logic [14:0] base, input bit bank, input int first, input int last);
        for (int w = first; w <= last; w++)
            serve_word(base + 15'(w), 32'h44332211 + w, 1'b1, bank, w);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending_writes: got %0d outstanding, required 0", name, sb.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_end: got %b, required 0", name, busy);
        end
    endtask

    task automatic watch_no_strobe(input string name);
        int seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (vif.vram_strobe !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL %s_no_request: got %0d strobe cycles, required 0", name, seen);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({vif.vram_strobe, buff_we, display_bank, busy, overrun} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got strobe/we/bank/busy/ovr=%b, required 00000",
                     {vif.vram_strobe, buff_we, display_bank, busy, overrun});
        end
        checks++;
        if ({vif.vram_addr, buff_addr, buff_data} !== 34'd0) begin
            errors++;
            $display("FAIL reset_buses: got vram_addr=%h buff_addr=%h buff_data=%h, required 0",
                     vif.vram_addr, buff_addr, buff_data);
        end
        rst_n = 1'b1;
        exp_cnt = 10'd0;
        exp_wr = 1'b1;
        exp_disp = 1'b0;
        exp_line_addr = 15'd0;
    endtask

    task automatic test_frame_fetch();
        layer_enable = 1'b1;
        wr_count = 0;
        pulse_frame(15'h0100);
        checks++;
        if (overrun !== 1'b0 || display_bank !== exp_disp) begin
            errors++;
            $display("FAIL frame_start: got overrun=%b bank=%b, required 0 %b", overrun, display_bank, exp_disp);
        end
        serve_line(exp_line_addr, exp_wr, 0, 159);
        wait_drain("frame_line0");
        checks++;
        if (last_req !== 15'h019F) begin
            errors++;
            $display("FAIL frame_last_addr: got %h, required 019f", last_req);
        end
        checks++;
        if (wr_count != 640) begin
            errors++;
            $display("FAIL frame_write_count: got %0d, required 640", wr_count);
        end
        checks++;
        if (vif.vram_strobe !== 1'b0) begin
            errors++;
            $display("FAIL frame_idle_strobe: got %b, required 0", vif.vram_strobe);
        end
    endtask

    task automatic test_next_line_overrun();
        logic [14:0] held;
        pulse_line();
        checks++;
        if (display_bank !== exp_disp) begin
            errors++;
            $display("FAIL line1_display_bank: got %b, required %b", display_bank, exp_disp);
        end
        serve_line(exp_line_addr, exp_wr, 0, 49);
        wait_strobe("word50");
        held = exp_line_addr + 15'd50;
        pulse_line();
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse: got %b, required 1", overrun);
        end
        checks++;
        if (vif.vram_strobe !== 1'b1 || vif.vram_addr !== held) begin
            errors++;
            $display("FAIL drain_hold: got strobe=%b addr=%h, required 1 %h", vif.vram_strobe, vif.vram_addr, held);
        end
        checks++;
        if (display_bank !== exp_disp) begin
            errors++;
            $display("FAIL line2_display_bank: got %b, required %b", display_bank, exp_disp);
        end
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_width: got %b, required 0", overrun);
        end
        serve_word(held, 32'hDEADBEEF, 1'b0, 1'b0, 50);
        serve_line(exp_line_addr, exp_wr, 0, 159);
        wait_drain("line2");
    endtask

    task automatic test_enable();
        layer_enable = 1'b0;
        pulse_line();
        checks++;
        if (display_bank !== exp_disp) begin
            errors++;
            $display("FAIL disabled_display_bank: got %b, required %b", display_bank, exp_disp);
        end
        watch_no_strobe("disabled_line");
        layer_enable = 1'b1;
        pulse_line();
        serve_word(exp_line_addr, 32'h44332211, 1'b1, exp_wr, 0);
        layer_enable = 1'b0;
        watch_no_strobe("enable_fall");
        wait_drain("enable_fall");
    endtask

    task automatic test_line_limit();
        layer_enable = 1'b0;
        while (exp_cnt != 10'd479) pulse_line();
        layer_enable = 1'b1;
        pulse_line();
        watch_no_strobe("line480");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL line480_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_frame_line_same();
        pulse_both(15'h0200);
        checks++;
        if (display_bank !== exp_disp || overrun !== 1'b0) begin
            errors++;
            $display("FAIL frame_wins: got bank=%b overrun=%b, required %b 0", display_bank, overrun, exp_disp);
        end
        serve_word(exp_line_addr, 32'hA1B2C3D4, 1'b1, exp_wr, 0);
        layer_enable = 1'b0;
        wait_drain("frame_wins");
    endtask

    task automatic test_reset_mid_req();
        layer_enable = 1'b0;
        if (exp_disp == 1'b0) pulse_line();
        layer_enable = 1'b1;
        pulse_frame(15'h0100);
        wait_strobe("pre_reset");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({vif.vram_strobe, buff_we, display_bank, busy} !== 4'b0 || vif.vram_addr !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid_req: got strobe/we/bank/busy=%b addr=%h, required 0000 0",
                     {vif.vram_strobe, buff_we, display_bank, busy}, vif.vram_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 10'd0;
        exp_wr = 1'b1;
        exp_disp = 1'b0;
        pulse_frame(15'h0100);
        serve_word(exp_line_addr, 32'h0BADF00D, 1'b1, exp_wr, 0);
        layer_enable = 1'b0;
        wait_drain("after_reset");
    endtask

    initial begin
        vif.vram_ack  = 1'b0;
        vif.vram_data = 32'd0;
        test_reset();
        test_frame_fetch();
        test_next_line_overrun();
        test_enable();
        test_line_limit();
        test_frame_line_same();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
